load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the EX-stage ALU in the non-pipelined core. It takes the ALU result as the effective address, plus rs2 data and funct3 from decode. It performs one RV32I load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) over a req/ack data-memory port. It returns a sign- or zero-extended load value to writeback, with a done pulse and a fault flag.

Parameters:
TIMEOUT, 16, maximum cycles in ACCESS waiting for mem_ack before faulting; 0 disables the timeout.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request strobe, sampled only in IDLE
is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code
addr  in  32  effective address (ALU res)
store_data  in  32  rs2 value
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
fault  out  1  valid with done: access not performed or timed out
load_data  out  32  formatted load result, held until next done
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  32  word address, bits [1:0] forced to 00
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE, and all outputs 0.
- Reset is asynchronous. If asserted mid-access, mem_req drops immediately, no done is issued, and any captured request is discarded.
- States: IDLE, ACCESS, DONE.
- IDLE with start=1: latch is_store, funct3, addr and store_data. Then:
  - If the funct3 is illegal, go to DONE with fault=1.
  - Else if misaligned and MISALIGN_TRAP_EN is defined, go to DONE with fault=1.
  - Else go to ACCESS.
- start is ignored outside IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- ACCESS:
  - mem_req=1, with mem_we/mem_addr/mem_wdata/mem_be registered and stable for the whole state.
  - On mem_ack=1: capture mem_rdata, go to DONE, and deassert mem_req the following cycle.
  - A wait-cycle counter starts at 0 on entry and increments each cycle without ack. When it reaches TIMEOUT-1 without ack, go to DONE with fault=1 and drop mem_req.
  - If ack arrives in the same cycle the counter expires, ack wins: no fault.
- DONE: done=1 for exactly one cycle, then return to IDLE. fault is valid only while done=1 and is 0 otherwise.
- Latency: start at edge N, mem_req high during cycle N+1. With zero wait states (ack in cycle N+1), done is high in cycle N+2. Each wait state adds 1 cycle. Illegal or trapped requests give done in cycle N+1 with no mem_req.
- Byte lanes (o = addr[1:0]):
  - Byte: be = 1<<o.
  - Half: be = 0011 if addr[1]=0, else 1100.
  - Word: be = 1111.
  - Loads drive the same be with mem_we=0.
- Store data: SB replicates store_data[7:0] x4, SH replicates store_data[15:0] x2, SW passes through.
- Load format:
  - LB/LBU select byte o; LH/LHU select half addr[1]; LW takes the full word.
  - Signed forms (LB, LH) sign-extend from the selected MSB; unsigned forms (LBU, LHU) zero-extend.
- load_data updates only on successful load completion. It is set to 0 on a store completion or any fault.
- Misalignment is defined as: half with addr[0]=1, or word with addr[1:0]!=00.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: misaligned accesses fault with no memory transaction (done+fault one cycle after start).
- Undefined: misalignment is silently tolerated. Half accesses ignore addr[0] and word accesses ignore addr[1:0], using the lane rules above; fault is never raised for alignment.

Test Plan:
1. LB: addr=0x103, mem_rdata=0x80FF_1234, ack in cycle N+1 -> be=1000, mem_addr=0x100, done at N+2, load_data=0xFFFF_FF80, fault=0.
2. SH: addr=0x22, store_data=0xDEAD_BEEF -> mem_we=1, be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x20. Ack after 3 wait cycles -> done 5 cycles after start, load_data=0.
3. LW with ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then done=1, fault=1, mem_req=0.
4. LH at addr=0x41 -> with MISALIGN_TRAP_EN: no mem_req, done+fault at N+1. Without it: be=0011 and load_data sign-extends rdata[15:0].
5. Load funct3=011 -> no mem_req, done+fault at N+1. start pulsed while busy -> ignored, no second access.
6. rst asserted during ACCESS -> mem_req low asynchronously, no done. After release, LBU at addr=0x2 with rdata=0x00AB_0000 -> load_data=0x0000_00AB.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack port.
// Optional macro MISALIGN_TRAP_EN: fault misaligned accesses up front.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam logic [31:0] TMO_LAST =
        (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [1:0]  state_q, state_d;
    logic        st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] ldata_q, ldata_d;

    logic        sz_b, sz_h, sz_w;
    logic        legal, misal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] fmt;

    // Decode the incoming request: legality, alignment, lanes, store data.
    always_comb begin
        sz_b = (funct3[1:0] == 2'b00);
        sz_h = (funct3[1:0] == 2'b01);
        sz_w = (funct3[1:0] == 2'b10);
        if (is_store) begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010,
                                   3'b100, 3'b101};
        end
        misal = (sz_h && addr[0]) ||
                (sz_w && (addr[1:0] != 2'b00));
        be_c    = 4'b0000;
        wdata_c = store_data;
        unique case (1'b1)
            sz_w: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
            sz_h: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
            end
            sz_b: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = store_data;
            end
        endcase
    end

    // Pick the addressed lane of the read word and extend it.
    always_comb begin
        unique case (off_q)
            2'd0:    lb = mem_rdata[7:0];
            2'd1:    lb = mem_rdata[15:8];
            2'd2:    lb = mem_rdata[23:16];
            default: lb = mem_rdata[31:24];
        endcase
        lh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (f3_q)
            3'b000:  fmt = {{24{lb[7]}}, lb};
            3'b001:  fmt = {{16{lh[15]}}, lh};
            3'b100:  fmt = {24'd0, lb};
            3'b101:  fmt = {16'd0, lh};
            default: fmt = mem_rdata;
        endcase
    end

    // Sequencing: IDLE -> ACCESS (or straight to DONE on fault) -> DONE.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        f3_d    = f3_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        ldata_d = ldata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_d  = is_store;
                    f3_d  = funct3;
                    off_d = addr[1:0];
                    if (!legal || (TRAP_EN && misal)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        ldata_d = 32'd0;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = 32'd0;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        maddr_d = {addr[31:2], 2'b00};
                        wdata_d = wdata_c;
                        be_d    = be_c;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ldata_d = st_q ? 32'd0 : fmt;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    maddr_d = 32'd0;
                    wdata_d = 32'd0;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    ldata_d = 32'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    maddr_d = 32'd0;
                    wdata_d = 32'd0;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            cnt_q   <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            ldata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            ldata_q <= ldata_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = ldata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule
